// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the RV32I control path.
//   - 4-bit FSM state codes and the state enum built on them
//   - major opcode constants
//   - immediate-format, ALU-op, source-select, result-select codes
//   - trap cause codes
package ctrl_pkg;

  // FSM state codes
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;
  localparam logic [3:0] ST_LUI      = 4'd11;
  localparam logic [3:0] ST_TRAP     = 4'd12;
  localparam logic [3:0] ST_JALR     = 4'd13;
  localparam logic [3:0] ST_JWB      = 4'd14;

  typedef enum logic [3:0] {
    StFetch    = ST_FETCH,
    StDecode   = ST_DECODE,
    StMemAdr   = ST_MEMADR,
    StMemRead  = ST_MEMREAD,
    StMemWb    = ST_MEMWB,
    StMemWrite = ST_MEMWRITE,
    StExecR    = ST_EXECR,
    StExecI    = ST_EXECI,
    StAluWb    = ST_ALUWB,
    StBeq      = ST_BEQ,
    StJal      = ST_JAL,
    StLui      = ST_LUI,
    StTrap     = ST_TRAP,
    StJalr     = ST_JALR,
    StJwb      = ST_JWB
  } state_e;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ALU control hints
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU source A
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU source B
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Trap causes
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: combinational opcode -> immediate-format select.
//   opc_i      instruction[6:0]
//   imm_src_o  immediate format (I/S/B/J/U); opcodes without an immediate map to I
module imm_src_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned IMM_W = 3
) (
  input  logic [6:0]       opc_i,
  output logic [IMM_W-1:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_W'(IMM_I);
    case (opc_i)
      OPC_STORE:  imm_src_o = IMM_W'(IMM_S);
      OPC_BRANCH: imm_src_o = IMM_W'(IMM_B);
      OPC_JAL:    imm_src_o = IMM_W'(IMM_J);
      OPC_LUI:    imm_src_o = IMM_W'(IMM_U);
      default:    imm_src_o = IMM_W'(IMM_I);
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-FSM control unit for a multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready, and parks
// in a sticky trap state on an illegal opcode or a memory wait timeout.
// Define JALR_EN to add JALR support (otherwise opcode 1100111 is illegal).
//   clk, reset_n          clock, synchronous active-low reset
//   opc, zero, mem_ready  opcode, ALU zero flag, memory handshake
//   pc_write .. reg_write datapath strobes and mux selects
//   imm_src               immediate format, decoded from opc in every state
//   trap, trap_cause      sticky error flag and its first cause
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned IMM_W    = 3,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         opc,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [IMM_W-1:0]   imm_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [1:0]       entry_cause;
  logic             is_wait, timeout;

  logic pc_update, branch, ir_write_s, mem_write_s, reg_write_s;

  imm_src_decoder #(
    .IMM_W(IMM_W)
  ) u_imm_src_decoder (
    .opc_i    (opc),
    .imm_src_o(imm_src)
  );

  // Next state, wait counter and trap capture
  always_comb begin
    state_d     = state_q;
    entry_cause = TRAP_NONE;
    is_wait     = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    timeout     = (WAIT_MAX != 0) && (wait_cnt_q == CNT_W'(WAIT_MAX));

    case (state_q)
      StFetch, StMemRead, StMemWrite: begin
        // A completing access beats a timeout on the same cycle
        if (mem_ready) begin
          state_d = (state_q == StFetch)   ? StDecode :
                    (state_q == StMemRead) ? StMemWb  : StFetch;
        end else if (timeout) begin
          state_d     = StTrap;
          entry_cause = TRAP_TIMEOUT;
        end
      end
      StDecode: begin
        case (opc)
          OPC_LOAD, OPC_STORE: state_d = StMemAdr;
          OPC_RTYPE:           state_d = StExecR;
          OPC_ITYPE:           state_d = StExecI;
          OPC_BRANCH:          state_d = StBeq;
          OPC_JAL:             state_d = StJal;
          OPC_LUI:             state_d = StLui;
`ifdef JALR_EN
          OPC_JALR:            state_d = StJalr;
`endif
          default: begin
            state_d     = StTrap;
            entry_cause = TRAP_ILLEGAL;
          end
        endcase
      end
      StMemAdr: state_d = opc[5] ? StMemWrite : StMemRead;
      StMemWb:  state_d = StFetch;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBeq:    state_d = StFetch;
      StJal:    state_d = StAluWb;
      StLui:    state_d = StAluWb;
      StTrap:   state_d = StTrap;
`ifdef JALR_EN
      StJalr:   state_d = StJwb;
      StJwb:    state_d = StAluWb;
`endif
      default:  state_d = StFetch;
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (is_wait && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // TRAP is absorbing, so only the first entry ever records a cause
    trap_d  = trap_q;
    cause_d = cause_q;
    if ((state_d == StTrap) && (state_q != StTrap)) begin
      trap_d  = 1'b1;
      cause_d = entry_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= TRAP_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
    end
  end

  // Moore output decode
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_W'(ALUOP_ADD);

    case (state_q)
      StFetch: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
      end
      StDecode: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      StMemAdr: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
      end
      StMemWrite: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      StExecR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_W'(ALUOP_FUNCT);
      end
      StExecI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_W'(ALUOP_FUNCT);
      end
      StAluWb: reg_write_s = 1'b1;
      StBeq: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_W'(ALUOP_SUB);
        branch    = 1'b1;
      end
      StJal: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      StLui: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
      end
`ifdef JALR_EN
      // Jump target rs1+imm goes straight to PC; link value OldPC+4 is formed in JWB
      StJalr: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      StJwb: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
`endif
      default: ;
    endcase
  end

  // Strobes are gated by reset so nothing is written while reset is held
  assign pc_write   = reset_n & (pc_update | (branch & zero));
  assign ir_write   = reset_n & ir_write_s;
  assign mem_write  = reset_n & mem_write_s;
  assign reg_write  = reset_n & reg_write_s;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and random stimulus against an instruction-level
// reference model (per-opcode micro-step lists, stall/timeout counting).
module tb_multicycle_control;

  localparam int unsigned WaitMax = 3;

  logic       clk = 1'b0;
  logic       reset_n, zero, mem_ready;
  logic [6:0] opc;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, trap_cause;
  logic [2:0] imm_src;

  always #5 clk = ~clk;

  multicycle_control #(
    .ALUOP_W (2),
    .IMM_W   (3),
    .WAIT_MAX(WaitMax),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opc       (opc),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .adr_src   (adr_src),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .result_src(result_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .imm_src   (imm_src),
    .alu_op    (alu_op),
    .reg_write (reg_write),
    .trap      (trap),
    .trap_cause(trap_cause)
  );

  // Micro-steps of an instruction, named by what happens in them
  typedef enum int {
    PFetch, PDecode, PAddr, PLoad, PLoadWb, PStore, PExR, PExI, PWb, PBranch, PJal,
    PLui, PTrap, PJalr, PJwb
  } phase_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] aop;
    logic       reg_write;
  } ctl_t;

  phase_e     ph;
  phase_e     seq[$];
  int         stall;
  logic       m_trap;
  logic [1:0] m_cause;
  int         errors = 0;
  int         checks = 0;

  logic [6:0] legal_opc[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b0110111, 7'b1100111};

  function automatic ctl_t expect_ctl(phase_e p, logic mr, logic z, logic rn);
    ctl_t c;
    c = '0;
    case (p)
      PFetch:  begin c.b = 2'b10; c.res = 2'b10; c.ir_write = mr; c.pc_write = mr; end
      PDecode: begin c.a = 2'b01; c.b = 2'b01; end
      PAddr:   begin c.a = 2'b10; c.b = 2'b01; end
      PLoad:   c.adr_src = 1'b1;
      PLoadWb: begin c.res = 2'b01; c.reg_write = 1'b1; end
      PStore:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      PExR:    begin c.a = 2'b10; c.aop = 2'b10; end
      PExI:    begin c.a = 2'b10; c.b = 2'b01; c.aop = 2'b10; end
      PWb:     c.reg_write = 1'b1;
      PBranch: begin c.a = 2'b10; c.aop = 2'b01; c.pc_write = z; end
      PJal:    begin c.a = 2'b01; c.b = 2'b10; c.pc_write = 1'b1; end
      PLui:    begin c.a = 2'b11; c.b = 2'b01; end
      PJalr:   begin c.a = 2'b10; c.b = 2'b01; c.res = 2'b10; c.pc_write = 1'b1; end
      PJwb:    begin c.a = 2'b01; c.b = 2'b10; end
      default: ;
    endcase
    if (!rn) begin
      c.pc_write = 1'b0; c.ir_write = 1'b0; c.mem_write = 1'b0; c.reg_write = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [2:0] expect_imm(logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Steps following FETCH for one instruction
  task automatic build_seq(input logic [6:0] o);
    seq.delete();
    seq.push_back(PDecode);
    case (o)
      7'b0000011: begin seq.push_back(PAddr); seq.push_back(PLoad); seq.push_back(PLoadWb); end
      7'b0100011: begin seq.push_back(PAddr); seq.push_back(PStore); end
      7'b0110011: begin seq.push_back(PExR); seq.push_back(PWb); end
      7'b0010011: begin seq.push_back(PExI); seq.push_back(PWb); end
      7'b1100011: seq.push_back(PBranch);
      7'b1101111: begin seq.push_back(PJal); seq.push_back(PWb); end
      7'b0110111: begin seq.push_back(PLui); seq.push_back(PWb); end
`ifdef JALR_EN
      7'b1100111: begin seq.push_back(PJalr); seq.push_back(PJwb); seq.push_back(PWb); end
`endif
      default:    seq.push_back(PTrap);
    endcase
  endtask

  task automatic model_edge(input logic mr, input logic rn);
    if (!rn) begin
      ph = PFetch; seq.delete(); stall = 0; m_trap = 1'b0; m_cause = 2'b00;
    end else if (ph == PTrap) begin
      // sticky
    end else if ((ph == PFetch || ph == PLoad || ph == PStore) && !mr) begin
      if (WaitMax > 0 && stall == int'(WaitMax)) begin
        ph = PTrap; stall = 0; m_trap = 1'b1; m_cause = 2'b10;
      end else begin
        stall++;
      end
    end else begin
      stall = 0;
      if (ph == PFetch) build_seq(opc);
      if (seq.size() == 0) ph = PFetch;
      else ph = seq.pop_front();
      if (ph == PTrap) begin m_trap = 1'b1; m_cause = 2'b01; end
    end
  endtask

  task automatic check(input string tag);
    ctl_t got, exp;
    got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_op, reg_write};
    exp = expect_ctl(ph, mem_ready, zero, reset_n);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s ctl step=%0d got=%h exp=%h", tag, ph, got, exp);
    end
    checks++;
    assert (imm_src === expect_imm(opc)) else begin
      errors++;
      $error("FAIL %s imm_src got=%b exp=%b", tag, imm_src, expect_imm(opc));
    end
    checks++;
    assert ({trap, trap_cause} === {m_trap, m_cause}) else begin
      errors++;
      $error("FAIL %s trap got=%b/%b exp=%b/%b", tag, trap, trap_cause, m_trap, m_cause);
    end
  endtask

  // One clock: drive at negedge, check, advance model at posedge
  task automatic cycle(input logic mr, input logic z, input logic rn, input string tag);
    mem_ready = mr; zero = z; reset_n = rn;
    #1;
    check(tag);
    @(posedge clk);
    model_edge(mr, rn);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opc = 7'b0000011;
    @(posedge clk);
    model_edge(1'b0, 1'b0);
    @(negedge clk);

    cycle(1'b1, 1'b0, 1'b0, "reset");

    // lw, zero-wait: 5 cycles
    opc = 7'b0000011;
    repeat (5) cycle(1'b1, 1'b0, 1'b1, "lw");
    // sw with 3 stall cycles in MEMWRITE
    opc = 7'b0100011;
    repeat (3) cycle(1'b1, 1'b0, 1'b1, "sw");
    repeat (3) cycle(1'b0, 1'b0, 1'b1, "sw_stall");
    cycle(1'b1, 1'b0, 1'b1, "sw_done");
    // beq taken then not taken
    opc = 7'b1100011;
    repeat (3) cycle(1'b1, 1'b1, 1'b1, "beq_t");
    repeat (3) cycle(1'b1, 1'b0, 1'b1, "beq_nt");
    // other classes
    opc = 7'b0110011; repeat (4) cycle(1'b1, 1'b0, 1'b1, "rtype");
    opc = 7'b0010011; repeat (4) cycle(1'b1, 1'b0, 1'b1, "itype");
    opc = 7'b1101111; repeat (4) cycle(1'b1, 1'b0, 1'b1, "jal");
    opc = 7'b0110111; repeat (4) cycle(1'b1, 1'b0, 1'b1, "lui");
    // illegal opcode: trap and hold
    opc = 7'b1111111;
    repeat (2) cycle(1'b1, 1'b0, 1'b1, "illegal");
    repeat (20) cycle(1'b1, 1'b0, 1'b1, "trap_hold");
    cycle(1'b1, 1'b0, 1'b0, "trap_reset");
    checks++;
    assert (trap === 1'b0) else begin
      errors++;
      $error("FAIL trap_clear got=%b exp=0", trap);
    end
    // fetch timeout after 4 cycles
    opc = 7'b0110011;
    repeat (4) cycle(1'b0, 1'b0, 1'b1, "fetch_to");
    repeat (2) cycle(1'b0, 1'b0, 1'b1, "to_hold");
    cycle(1'b0, 1'b0, 1'b0, "to_reset");
    // ready on the 4th cycle wins over the timeout
    repeat (3) cycle(1'b0, 1'b0, 1'b1, "fetch_wait");
    cycle(1'b1, 1'b0, 1'b1, "fetch_last");
    repeat (3) cycle(1'b1, 1'b0, 1'b1, "after_wait");
    // reset asserted mid-MEMWRITE
    opc = 7'b0100011;
    repeat (3) cycle(1'b1, 1'b0, 1'b1, "sw2");
    cycle(1'b0, 1'b0, 1'b1, "sw2_stall");
    cycle(1'b0, 1'b0, 1'b0, "sw2_reset");
    cycle(1'b1, 1'b0, 1'b1, "sw2_fetch");

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic mr, z, rn;
      if (ph == PFetch) begin
        if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
        else opc = legal_opc[$urandom_range(0, 7)];
      end
      mr = ($urandom_range(0, 9) < 7);
      z  = 1'($urandom);
      rn = (ph == PTrap) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 99) != 0);
      cycle(mr, z, rn, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
